cva6_pma_table: RTL and testbench

- Runtime-programmable physical memory attribute (PMA) table.
- Generalises the static region rules fixed at elaboration (non-idempotent, execute, cached base/length lists) into NrRules writable entries.
- Each entry has {base, length, attr}; entries reset to parameter values.
- Serves NrPorts parallel lookup channels (fetch, load/store, PTW) through a registered 1-cycle lookup pipeline.
- Sits beside the MMU/PMP; programmed by the CSR unit over a valid/ready request/response handshake.

---
 rtl/cva6_pma_pkg.sv | 33 +++
 rtl/cva6_pma_match.sv | 40 ++++
 rtl/cva6_pma_table.sv | 191 +++++++++++++++++++
 tb/tb_cva6_pma_table.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cva6_pma_pkg.sv
// Shared types for the runtime-programmable PMA table.
// Optional lock support is enabled with `define CVA6_PMA_LOCK_EN.
package cva6_pma_pkg;

    localparam int unsigned PmaAddrWidth = 64;

    typedef struct packed {
        logic lock;
        logic exec;
        logic cached;
        logic nonidem;
    } pma_attr_t;

    typedef enum logic [1:0] {
        FieldBase   = 2'd0,
        FieldLength = 2'd1,
        FieldAttr   = 2'd2,
        FieldRsvd   = 2'd3
    } pma_field_e;

    typedef struct packed {
        logic [PmaAddrWidth-1:0] base;
        logic [PmaAddrWidth-1:0] length;
        pma_attr_t               attr;
    } pma_rule_t;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } pma_state_e;

endpackage

// File: rtl/cva6_pma_match.sv
// Combinational region comparator and priority encoder for one lookup port.
// Lowest matching entry index wins; a disabled entry has length 0.
module cva6_pma_match #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned NrRules   = 8
) (
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [AddrWidth-1:0] base_i   [NrRules],
    input  logic [AddrWidth-1:0] length_i [NrRules],
    input  logic [2:0]           attr_i   [NrRules],
    output logic                 hit_o,
    output logic [2:0]           attr_o
);

    logic [NrRules-1:0] match;

    // Region test; the end bound uses one extra bit so it never wraps low.
    always_comb begin
        match = '0;
        for (int i = 0; i < int'(NrRules); i++) begin
            match[i] = (length_i[i] != '0)
                    && (addr_i >= base_i[i])
                    && ({1'b0, addr_i} <
                        ({1'b0, base_i[i]} + {1'b0, length_i[i]}));
        end
    end

    // Priority encode: scan downwards so the lowest index is applied last.
    always_comb begin
        hit_o  = 1'b0;
        attr_o = '0;
        for (int i = int'(NrRules) - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_o  = 1'b1;
                attr_o = attr_i[i];
            end
        end
    end

endmodule

// File: rtl/cva6_pma_table.sv
// Runtime-programmable PMA table with NrPorts registered lookup channels.
// Define CVA6_PMA_LOCK_EN to make attr bit 3 a sticky per-entry write lock.
module cva6_pma_table
    import cva6_pma_pkg::*;
#(
    parameter int unsigned             AddrWidth = 64,
    parameter int unsigned             NrRules   = 8,
    parameter int unsigned             NrPorts   = 2,
    parameter logic [NrRules*AddrWidth-1:0] RstBase   = '0,
    parameter logic [NrRules*AddrWidth-1:0] RstLength = '0,
    parameter logic [NrRules*3-1:0]         RstAttr   = '0,
    localparam int unsigned IdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_req_valid_i,
    output logic                         cfg_req_ready_o,
    input  logic                         cfg_we_i,
    input  logic [IdxWidth-1:0]          cfg_idx_i,
    input  logic [1:0]                   cfg_field_i,
    input  logic [AddrWidth-1:0]         cfg_wdata_i,
    output logic                         cfg_rsp_valid_o,
    input  logic                         cfg_rsp_ready_i,
    output logic [AddrWidth-1:0]         cfg_rdata_o,
    output logic                         cfg_err_o,
    input  logic [NrPorts-1:0]           lookup_valid_i,
    input  logic [NrPorts*AddrWidth-1:0] lookup_addr_i,
    output logic [NrPorts-1:0]           lookup_valid_o,
    output logic [NrPorts-1:0]           lookup_hit_o,
    output logic [NrPorts*3-1:0]         lookup_attr_o
);

    pma_rule_t      rules_q [NrRules];
    pma_state_e     state_q;
    logic           we_q;
    logic [IdxWidth-1:0] idx_q;
    pma_field_e     field_q;
    logic [AddrWidth-1:0] wdata_q;
    logic           req_ready_q;
    logic           rsp_valid_q;
    logic [AddrWidth-1:0] rdata_q;
    logic           err_q;

    logic [NrPorts-1:0]   lk_valid_q;
    logic [NrPorts-1:0]   lk_hit_q;
    logic [NrPorts*3-1:0] lk_attr_q;

    logic [AddrWidth-1:0] base_s [NrRules];
    logic [AddrWidth-1:0] len_s  [NrRules];
    logic [2:0]           attr_s [NrRules];
    logic                 m_hit  [NrPorts];
    logic [2:0]           m_attr [NrPorts];

    pma_rule_t            cur_rule;
    logic                 idx_ok;
    logic                 locked;
    logic [AddrWidth-1:0] rdata_d;
    logic                 err_d;
    pma_attr_t            wattr;

    // Flatten the table into the comparator-facing views.
    always_comb begin
        for (int i = 0; i < int'(NrRules); i++) begin
            base_s[i] = AddrWidth'(rules_q[i].base);
            len_s[i]  = AddrWidth'(rules_q[i].length);
            attr_s[i] = {rules_q[i].attr.exec,
                         rules_q[i].attr.cached,
                         rules_q[i].attr.nonidem};
        end
    end

    for (genvar p = 0; p < NrPorts; p++) begin : g_port
        cva6_pma_match #(
            .AddrWidth (AddrWidth),
            .NrRules   (NrRules)
        ) u_match (
            .addr_i   (lookup_addr_i[p*AddrWidth +: AddrWidth]),
            .base_i   (base_s),
            .length_i (len_s),
            .attr_i   (attr_s),
            .hit_o    (m_hit[p]),
            .attr_o   (m_attr[p])
        );
    end

    // Old value, error status and new attr for the latched request.
    always_comb begin
        idx_ok   = int'(idx_q) < int'(NrRules);
        cur_rule = rules_q[idx_q];
`ifdef CVA6_PMA_LOCK_EN
        locked        = cur_rule.attr.lock;
        wattr.lock    = wdata_q[3];
`else
        locked        = 1'b0;
        wattr.lock    = 1'b0;
`endif
        wattr.exec    = wdata_q[2];
        wattr.cached  = wdata_q[1];
        wattr.nonidem = wdata_q[0];
        rdata_d = '0;
        unique case (field_q)
            FieldBase:   rdata_d = AddrWidth'(cur_rule.base);
            FieldLength: rdata_d = AddrWidth'(cur_rule.length);
            FieldAttr:   rdata_d = AddrWidth'(cur_rule.attr);
            default:     rdata_d = '0;
        endcase
        if (!idx_ok) rdata_d = '0;
        err_d = (field_q == FieldRsvd) || !idx_ok || (we_q && locked);
    end

    // Config handshake FSM and table storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            idx_q       <= '0;
            field_q     <= FieldBase;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < int'(NrRules); i++) begin
                rules_q[i].base   <= PmaAddrWidth'(RstBase[i*AddrWidth +: AddrWidth]);
                rules_q[i].length <= PmaAddrWidth'(RstLength[i*AddrWidth +: AddrWidth]);
                rules_q[i].attr   <= {1'b0, RstAttr[i*3 +: 3]};
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cfg_req_valid_i) begin
                        we_q        <= cfg_we_i;
                        idx_q       <= cfg_idx_i;
                        field_q     <= pma_field_e'(cfg_field_i);
                        wdata_q     <= cfg_wdata_i;
                        req_ready_q <= 1'b0;
                        state_q     <= StExec;
                    end
                end
                StExec: begin
                    rdata_q     <= rdata_d;
                    err_q       <= err_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                    if (we_q && !err_d) begin
                        unique case (field_q)
                            FieldBase:   rules_q[idx_q].base   <= PmaAddrWidth'(wdata_q);
                            FieldLength: rules_q[idx_q].length <= PmaAddrWidth'(wdata_q);
                            FieldAttr:   rules_q[idx_q].attr   <= wattr;
                            default: ;
                        endcase
                    end
                end
                StResp: begin
                    if (cfg_rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Lookup result registers; hit/attr hold while the channel is idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lk_valid_q <= '0;
            lk_hit_q   <= '0;
            lk_attr_q  <= '0;
        end else begin
            lk_valid_q <= lookup_valid_i;
            for (int p = 0; p < int'(NrPorts); p++) begin
                if (lookup_valid_i[p]) begin
                    lk_hit_q[p]         <= m_hit[p];
                    lk_attr_q[p*3 +: 3] <= m_attr[p];
                end
            end
        end
    end

    assign cfg_req_ready_o = req_ready_q;
    assign cfg_rsp_valid_o = rsp_valid_q;
    assign cfg_rdata_o     = rdata_q;
    assign cfg_err_o       = err_q;
    assign lookup_valid_o  = lk_valid_q;
    assign lookup_hit_o    = lk_hit_q;
    assign lookup_attr_o   = lk_attr_q;

endmodule

// File: tb/tb_cva6_pma_table.sv
// Scoreboard bench for cva6_pma_table: directed config and lookup vectors.
// Runs in both builds; lock expectations follow CVA6_PMA_LOCK_EN.
module tb_cva6_pma_table;

    localparam int AW = 64;
    localparam int NR = 8;
    localparam int NP = 2;
`ifdef CVA6_PMA_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif
    localparam logic [NR*AW-1:0] TbRstBase = 512'h8000_0000;
    localparam logic [NR*AW-1:0] TbRstLen  = 512'h4000_0000;
    localparam logic [NR*3-1:0]  TbRstAttr = 24'h6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_req_valid_i = 1'b0;
    logic cfg_req_ready_o;
    logic cfg_we_i = 1'b0;
    logic [2:0] cfg_idx_i = '0;
    logic [1:0] cfg_field_i = '0;
    logic [AW-1:0] cfg_wdata_i = '0;
    logic cfg_rsp_valid_o;
    logic cfg_rsp_ready_i = 1'b1;
    logic [AW-1:0] cfg_rdata_o;
    logic cfg_err_o;
    logic [NP-1:0] lookup_valid_i = '0;
    logic [NP*AW-1:0] lookup_addr_i = '0;
    logic [NP-1:0] lookup_valid_o;
    logic [NP-1:0] lookup_hit_o;
    logic [NP*3-1:0] lookup_attr_o;

    int checks = 0;
    int errors = 0;
    logic [64:0] cq [$];
    logic [3:0]  lq0 [$];
    logic [3:0]  lq1 [$];
    logic [64:0] mon_e;
    logic [3:0]  mon_l;

    cva6_pma_table #(
        .AddrWidth (AW),
        .NrRules   (NR),
        .NrPorts   (NP),
        .RstBase   (TbRstBase),
        .RstLength (TbRstLen),
        .RstAttr   (TbRstAttr)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_req_valid_i (cfg_req_valid_i),
        .cfg_req_ready_o (cfg_req_ready_o),
        .cfg_we_i        (cfg_we_i),
        .cfg_idx_i       (cfg_idx_i),
        .cfg_field_i     (cfg_field_i),
        .cfg_wdata_i     (cfg_wdata_i),
        .cfg_rsp_valid_o (cfg_rsp_valid_o),
        .cfg_rsp_ready_i (cfg_rsp_ready_i),
        .cfg_rdata_o     (cfg_rdata_o),
        .cfg_err_o       (cfg_err_o),
        .lookup_valid_i  (lookup_valid_i),
        .lookup_addr_i   (lookup_addr_i),
        .lookup_valid_o  (lookup_valid_o),
        .lookup_hit_o    (lookup_hit_o),
        .lookup_attr_o   (lookup_attr_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pops and compares whenever the DUT presents a result.
    always @(negedge clk) begin
        if (!rst) begin
            if (cfg_rsp_valid_o && cfg_rsp_ready_i) begin
                if (cq.size() == 0) flag("cfg_rsp unexpected response");
                else begin
                    mon_e = cq.pop_front();
                    chk("cfg_rdata", cfg_rdata_o, mon_e[63:0]);
                    chk("cfg_err", {63'b0, cfg_err_o}, {63'b0, mon_e[64]});
                end
            end
            if (lookup_valid_o[0]) begin
                if (lq0.size() == 0) flag("lookup0 unexpected valid");
                else begin
                    mon_l = lq0.pop_front();
                    chk("lookup0 {hit,attr}",
                        {60'b0, lookup_hit_o[0], lookup_attr_o[2:0]},
                        {60'b0, mon_l});
                end
            end
            if (lookup_valid_o[1]) begin
                if (lq1.size() == 0) flag("lookup1 unexpected valid");
                else begin
                    mon_l = lq1.pop_front();
                    chk("lookup1 {hit,attr}",
                        {60'b0, lookup_hit_o[1], lookup_attr_o[5:3]},
                        {60'b0, mon_l});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lk(input int p, input logic [63:0] a,
                      input logic h, input logic [2:0] at);
        if (p == 0) lq0.push_back({h, at});
        else        lq1.push_back({h, at});
        lookup_valid_i[p] = 1'b1;
        lookup_addr_i[p*AW +: AW] = a;
        tick();
        lookup_valid_i[p] = 1'b0;
    endtask

    task automatic cfg_start(input logic we, input logic [2:0] idx,
                             input logic [1:0] f, input logic [63:0] wd,
                             input logic [63:0] er, input logic ee,
                             input logic push);
        int n;
        if (push) cq.push_back({ee, er});
        cfg_we_i = we;
        cfg_idx_i = idx;
        cfg_field_i = f;
        cfg_wdata_i = wd;
        cfg_req_valid_i = 1'b1;
        n = 0;
        while (!cfg_req_ready_o && n < 20) begin
            tick();
            n++;
        end
        if (!cfg_req_ready_o) flag("cfg_req_ready timeout");
        tick();
        cfg_req_valid_i = 1'b0;
    endtask

    task automatic cfg_wait();
        int n;
        n = 0;
        while (!(cfg_req_ready_o && !cfg_rsp_valid_o) && n < 20) begin
            tick();
            n++;
        end
        if (!(cfg_req_ready_o && !cfg_rsp_valid_o)) flag("cfg_rsp timeout");
    endtask

    task automatic cfg(input logic we, input logic [2:0] idx,
                       input logic [1:0] f, input logic [63:0] wd,
                       input logic [63:0] er, input logic ee);
        cfg_start(we, idx, f, wd, er, ee, 1'b1);
        cfg_wait();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", {63'b0, cfg_req_ready_o}, 64'd1);
        chk("rst rsp_valid", {63'b0, cfg_rsp_valid_o}, 64'd0);
        chk("rst rdata", cfg_rdata_o, 64'd0);
        chk("rst err", {63'b0, cfg_err_o}, 64'd0);
        chk("rst lookup", {57'b0, lookup_valid_o, lookup_hit_o, lookup_attr_o[2:0]}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Reset-programmed region
        lk(0, 64'h8000_1000, 1'b1, 3'b110);
        lk(0, 64'hC000_0000, 1'b0, 3'b000);
        lk(1, 64'hBFFF_FFFF, 1'b1, 3'b110);
        tick();
        chk("held hit1", {63'b0, lookup_hit_o[1]}, 64'd1);
        chk("held attr1", {61'b0, lookup_attr_o[5:3]}, 64'd6);

        // Write ordering against a lookup in the EXEC cycle
        cfg(1'b1, 3'd2, 2'd0, 64'h2000, 64'h0, 1'b0);
        cfg_start(1'b1, 3'd2, 2'd1, 64'h1000, 64'h0, 1'b0, 1'b1);
        lk(1, 64'h2FFF, 1'b0, 3'b000);
        cfg_wait();
        lk(1, 64'h2FFF, 1'b1, 3'b000);
        lk(1, 64'h3000, 1'b0, 3'b000);
        cfg(1'b0, 3'd2, 2'd1, 64'h0, 64'h1000, 1'b0);
        cfg(1'b1, 3'd2, 2'd2, 64'hF6, 64'h0, 1'b0);
        cfg(1'b0, 3'd2, 2'd2, 64'h0, 64'h6, 1'b0);
        lk(0, 64'h2000, 1'b1, 3'b110);

        // Top of address space, no wrap
        cfg(1'b1, 3'd4, 2'd0, 64'hFFFF_FFFF_FFFF_F000, 64'h0, 1'b0);
        cfg(1'b1, 3'd4, 2'd1, 64'h2000, 64'h0, 1'b0);
        cfg(1'b1, 3'd4, 2'd2, 64'h3, 64'h0, 1'b0);
        lk(0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 3'b011);
        lk(0, 64'h0, 1'b0, 3'b000);
        lk(1, 64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 3'b000);

        // Overlap priority
        cfg(1'b1, 3'd1, 2'd0, 64'h1_0000, 64'h0, 1'b0);
        cfg(1'b1, 3'd1, 2'd1, 64'h1_0000, 64'h0, 1'b0);
        cfg(1'b1, 3'd1, 2'd2, 64'h1, 64'h0, 1'b0);
        cfg(1'b1, 3'd3, 2'd1, 64'h10_0000, 64'h0, 1'b0);
        cfg(1'b1, 3'd3, 2'd2, 64'h4, 64'h0, 1'b0);
        lk(0, 64'h1_8000, 1'b1, 3'b001);
        lk(0, 64'h2_0000, 1'b1, 3'b100);
        lk(1, 64'h2800, 1'b1, 3'b110);
        lk(1, 64'h10_0000, 1'b0, 3'b000);

        // Response backpressure
        cfg_rsp_ready_i = 1'b0;
        cfg_start(1'b0, 3'd4, 2'd0, 64'h0, 64'hFFFF_FFFF_FFFF_F000, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp rsp_valid", {63'b0, cfg_rsp_valid_o}, 64'd1);
            chk("bp rdata", cfg_rdata_o, 64'hFFFF_FFFF_FFFF_F000);
            chk("bp req_ready", {63'b0, cfg_req_ready_o}, 64'd0);
            tick();
        end
        cfg_rsp_ready_i = 1'b1;
        cfg_wait();

        // Reserved field
        cfg(1'b0, 3'd1, 2'd3, 64'h0, 64'h0, 1'b1);
        cfg(1'b1, 3'd1, 2'd3, 64'h1234, 64'h0, 1'b1);
        cfg(1'b0, 3'd1, 2'd0, 64'h0, 64'h1_0000, 1'b0);

        // Lock bit (inert without the lock build)
        cfg(1'b1, 3'd0, 2'd2, 64'h9, 64'h6, 1'b0);
        cfg(1'b1, 3'd0, 2'd0, 64'h0, 64'h8000_0000, LockEn);
        cfg(1'b0, 3'd0, 2'd0, 64'h0, LockEn ? 64'h8000_0000 : 64'h0, 1'b0);
        cfg(1'b0, 3'd0, 2'd2, 64'h0, LockEn ? 64'h9 : 64'h1, 1'b0);
        cfg(1'b1, 3'd0, 2'd2, 64'h0, LockEn ? 64'h9 : 64'h1, LockEn);

        // Reset during RESP
        cfg_rsp_ready_i = 1'b0;
        cfg_start(1'b0, 3'd0, 2'd0, 64'h0, 64'h0, 1'b0, 1'b0);
        tick();
        chk("pre-rst rsp_valid", {63'b0, cfg_rsp_valid_o}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst rsp_valid drop", {63'b0, cfg_rsp_valid_o}, 64'd0);
        chk("rst req_ready set", {63'b0, cfg_req_ready_o}, 64'd1);
        cfg_rsp_ready_i = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        lk(0, 64'h8000_1000, 1'b1, 3'b110);
        lk(0, 64'h1_8000, 1'b0, 3'b000);
        lk(1, 64'h2800, 1'b0, 3'b000);
        cfg(1'b1, 3'd0, 2'd0, 64'h8000_0000, 64'h8000_0000, 1'b0);

        repeat (3) tick();
        chk("cfg queue drained", 64'(cq.size()), 64'd0);
        chk("lookup0 queue drained", 64'(lq0.size()), 64'd0);
        chk("lookup1 queue drained", 64'(lq1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
